// File: rtl/line_engine.sv
// Bresenham line rasteriser: loads endpoints/colour while idle, then emits one
// frame-buffer pixel per cycle (clipped pixels still take a cycle, with we=0).
module line_engine #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int AW     = 19
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [9:0]    line_point,
    input  logic          line_x0_valid,
    input  logic          line_y0_valid,
    input  logic          line_x1_valid,
    input  logic          line_y1_valid,
    input  logic [31:0]   line_color,
    input  logic          line_color_valid,
    input  logic          line_trigger,
    output logic          line_ready,
    output logic          vram_we,
    output logic [AW-1:0] vram_wa,
    output logic [31:0]   vram_wd,
    output logic [1:0]    dbg_state_o
);
    // Handshake: strobes and line_trigger are accepted only in a cycle where
    // line_ready=1; anything presented while busy is dropped.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_DRAW = 2'd2} state_t;

    localparam logic [AW:0] ROW   = (AW+1)'(WIDTH);
    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [10:0] X_LIM = 11'(WIDTH);
    localparam logic [10:0] Y_LIM = 11'(HEIGHT);

    state_t              state_q, state_d;
    logic [9:0]          x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [31:0]         color_q, color_d;
    logic [10:0]         x_q, x_d, y_q, y_d;
    logic [AW:0]         addr_q, addr_d;
    logic signed [11:0]  err_q, err_d, dx_q, dx_d, dy_q, dy_d;
    logic                sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    logic signed [12:0]  e2, dx_e, dy_e;
    logic [9:0]          adx, ady;
    logic                step_x, step_y, last;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        color_d  = color_q;
        x_d      = x_q;
        y_d      = y_q;
        addr_d   = addr_q;
        err_d    = err_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;

        adx    = (x1_q > x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady    = (y1_q > y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        e2     = {err_q, 1'b0};
        dx_e   = {dx_q[11], dx_q};
        dy_e   = {dy_q[11], dy_q};
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        last   = (x_q == {1'b0, x1_q}) && (y_q == {1'b0, y1_q});

        case (state_q)
            S_IDLE: begin
                if (line_x0_valid)    x0_d    = line_point;
                if (line_y0_valid)    y0_d    = line_point;
                if (line_x1_valid)    x1_d    = line_point;
                if (line_y1_valid)    y1_d    = line_point;
                if (line_color_valid) color_d = line_color;
                if (line_trigger)     state_d = S_SETUP;
            end
            S_SETUP: begin
                dx_d     = {2'b00, adx};
                dy_d     = 12'sd0 - $signed({2'b00, ady});
                err_d    = $signed({2'b00, adx}) - $signed({2'b00, ady});
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                x_d      = {1'b0, x0_q};
                y_d      = {1'b0, y0_q};
                addr_d   = ({{(AW-9){1'b0}}, y0_q} * ROW) + {{(AW-9){1'b0}}, x0_q};
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    // Both steps are judged against the same e2; err accumulates.
                    if (step_x) begin
                        err_d  = err_d + dy_q;
                        x_d    = sx_neg_q ? (x_q - 11'd1) : (x_q + 11'd1);
                        addr_d = sx_neg_q ? (addr_d - ONE) : (addr_d + ONE);
                    end
                    if (step_y) begin
                        err_d  = err_d + dx_q;
                        y_d    = sy_neg_q ? (y_q - 11'd1) : (y_q + 11'd1);
                        addr_d = sy_neg_q ? (addr_d - ROW) : (addr_d + ROW);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            color_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            err_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            color_q  <= color_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    // Pixel outputs come straight from the DRAW-state registers.
    assign line_ready  = (state_q == S_IDLE);
    assign vram_we     = (state_q == S_DRAW) && (x_q < X_LIM) && (y_q < Y_LIM);
    assign vram_wa     = addr_q[AW-1:0];
    assign vram_wd     = color_q;
    assign dbg_state_o = state_q;
endmodule

// File: doc/line_engine.md
# line_engine

Bresenham line rasteriser that writes one pixel per cycle into the frame buffer (`vram` write port), the producer of what `PixelFeeder` later scans out to `DVI`. The CPU side loads colour and endpoints through strobed registers, pulses `line_trigger`, and watches `line_ready`. The engine operates in screen space of `WIDTH`×`HEIGHT`, one 32-bit word per pixel, and computes the address as `y*WIDTH + x`.

## Interface
- `WIDTH`, 800, visible pixels per line; also the row pitch in words.
- `HEIGHT`, 600, visible lines.
- `AW`, 19, VRAM word-address width.
- `clk`  in  1  single clock (`cpu_clk_g` domain); everything is rising-edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `line_point`  in  10  coordinate value, unsigned 0..1023, qualified by one of the four strobes below.
- `line_x0_valid` / `line_y0_valid` / `line_x1_valid` / `line_y1_valid`  in  1 each  load `line_point` into the named endpoint register.
- `line_color`  in  32  pixel word.
- `line_color_valid`  in  1  load `line_color`.
- `line_trigger`  in  1  start drawing from the current registers.
- `line_ready`  out  1  high in IDLE: loads and trigger are accepted.
- `vram_we`  out  1  write strobe for one pixel.
- `vram_wa`  out  AW  write address, `y*WIDTH+x`.
- `vram_wd`  out  32  write data, the latched colour.

## Operation
- **Load path.**
  - The strobes load registers only while `line_ready`=1.
  - Strobes seen while busy are ignored and the registers hold their values.
  - If several strobes are high in one cycle, all of them load `line_point`.
- **IDLE.**
  - `line_ready`=1, `vram_we`=0.
  - `line_trigger`=1 moves to SETUP. Strobes in the same cycle still load, and SETUP uses the new values.
- **SETUP** (1 cycle), computes:
  - `dx=|x1-x0|`, `dy=-|y1-y0|`.
  - `sx=+1` if `x0<x1`, otherwise −1; `sy` likewise from the y values.
  - `err=dx+dy`.
  - `x=x0`, `y=y0`, `addr=y0*WIDTH+x0`. The constant multiply is allowed in this cycle.
- **DRAW** (one pixel per cycle).
  - Output pixel `(x,y)`: `vram_wa=addr[AW-1:0]`, `vram_wd=color`, `vram_we=(x<WIDTH)&&(y<HEIGHT)`.
  - If `x==x1 && y==y1`, go to IDLE.
  - Otherwise set `e2=2*err`, then apply both updates below, each evaluated against the same `e2`:
    - If `e2>=dy`: `err+=dy`, `x+=sx`, `addr+=sx`.
    - If `e2<=dx`: `err+=dx`, `y+=sy`, `addr+=sy*WIDTH`.
- **Widths.**
  - `err`: 12-bit signed; `e2`: 13-bit signed.
  - `x`, `y`: 11-bit, so no wrap occurs during clipping.
  - `addr`: unsigned, AW+1 = 20 bits; its maximum is 1023*800+1023 = 819,423.
- **Clipping.** Off-screen pixels take a DRAW cycle with `vram_we`=0. Stepping is unaffected.
- **Degenerate line.** A line with `x0==x1`, `y0==y1` takes exactly 1 DRAW cycle.
- **Reset.** Asserting `rst_b` low at any time, including mid-DRAW:
  - Goes to IDLE immediately.
  - Outputs: `line_ready`=1, `vram_we`=0, `vram_wa`=0, `vram_wd`=0.
  - All endpoint registers and the colour register reset to 0.

## Timing
- `line_trigger` sampled at edge k:
  - SETUP occupies the cycle after edge k.
  - The first pixel is presented after edge k+1.
  - The last pixel is presented after edge k+N, where `N=max(dx,|dy|)+1`.
  - `line_ready` returns high after edge k+N+1.
- `line_ready` is low from edge k through edge k+N+1, a total of N+1 cycles including SETUP.
- VRAM write latency: `vram_we`/`wa`/`wd` are registered outputs. The VRAM captures them on the edge that ends the cycle in which they are presented.
- Throughput: exactly one DRAW cycle per Bresenham step, with no bubbles.
- Back-to-back lines: a new trigger is accepted in the first cycle `line_ready` is high.

## Test plan
- **Horizontal.** Colour 0x00ff0000, (0,0)→(3,0), trigger.
  - Writes at `vram_wa` 0, 1, 2, 3 on 4 consecutive cycles, all with `wd`=0x00ff0000.
  - Ready is low for 5 cycles.
- **Vertical.** (5,2)→(5,4): writes at 1605, 2405, 3205.
- **Shallow, then reversed steep.**
  - (0,0)→(4,2): writes at 0, 801, 802, 1603, 1604.
  - (799,599)→(797,597): writes at 479999, 479198, 478397.
- **Clipping.** (798,0)→(801,0): 4 DRAW cycles. `we`=1 for addresses 798 and 799, `we`=0 for the next 2 cycles.
- **Point and busy-ignore.**
  - (10,10)→(10,10): a single write at 8010.
  - During a long line, pulse `line_x0_valid` and `line_trigger`: there is no effect, and the next line uses the old x0.
- **Reset mid-line.** Drop `rst_b` during DRAW of (0,0)→(100,0).
  - Same cycle: `vram_we`=0 and `line_ready`=1, with no further writes after release.
  - After release, (0,0)→(0,0) writes only address 0.
